// File: rtl/mux_scan_sequencer.sv
// Steps the mux select through all N channels, holding each for SETTLE+1 cycles and sampling on the last; word valid N*(SETTLE+1) cycles after start.
// A finished word is held with s parked at N-1 until valid&&ready; continuous mode restarts the scan right after the transfer.
module mux_scan_sequencer #(
  parameter int SEL_W  = 3,
  parameter int SETTLE = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  continuous,
  output logic [SEL_W-1:0]      s,
  input  logic                  mux_out,
  output logic [2**SEL_W-1:0]   data,
  output logic                  valid,
  input  logic                  ready,
  output logic                  busy
);

  localparam int N = 2**SEL_W;
  localparam logic [3:0]       SETTLE_LAST = 4'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam logic [SEL_W-1:0] LAST_CH     = SEL_W'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  // Every channel window opens here; with no settle time the window is just the sample cycle.
  localparam state_t ST_WINDOW = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;

  state_t           state, state_nxt;
  logic [3:0]       cnt, cnt_nxt;
  logic [SEL_W-1:0] s_nxt;
  logic [N-1:0]     shadow, shadow_nxt;
  logic [N-1:0]     data_nxt;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    s_nxt      = s;
    shadow_nxt = shadow;
    data_nxt   = data;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_WINDOW;
          s_nxt     = '0;
          cnt_nxt   = '0;
        end
      end
      ST_SETTLE: begin
        if (cnt == SETTLE_LAST) begin
          state_nxt = ST_SAMPLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      ST_SAMPLE: begin
        shadow_nxt[s] = mux_out;
        // The last channel's bit goes straight into the published word alongside the rest.
        if (s == LAST_CH) begin
          data_nxt  = shadow_nxt;
          state_nxt = ST_DONE;
        end else begin
          s_nxt     = s + 1'b1;
          state_nxt = ST_WINDOW;
        end
      end
      ST_DONE: begin
        if (valid && ready) begin
          s_nxt     = '0;
          cnt_nxt   = '0;
          state_nxt = continuous ? ST_WINDOW : ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      s      <= '0;
      shadow <= '0;
      data   <= '0;
      valid  <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      s      <= s_nxt;
      shadow <= shadow_nxt;
      data   <= data_nxt;
      valid  <= (state_nxt == ST_DONE);
      busy   <= (state_nxt != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Randomised bench with a timeline reference model and a word scoreboard; covers SETTLE=1 and SETTLE=0 builds.
module tb_mux_scan_sequencer;

  localparam int N = 8;

  typedef struct {
    int         mode;   // 0 idle, 1 scanning, 2 word pending
    int         b;      // first cycle of the current scan
    int         cyc;    // index of the current cycle
    logic [7:0] word;
    logic [7:0] data;
  } mstate_t;

  typedef struct {
    logic [7:0] word;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_reset, a_start, a_cont, a_ready, a_mux_out, a_valid, a_busy;
  logic [2:0] a_s;
  logic [7:0] a_data, a_mux;
  logic       b_reset, b_start, b_cont, b_ready, b_mux_out, b_valid, b_busy;
  logic [2:0] b_s;
  logic [7:0] b_data, b_mux;

  assign a_mux_out = a_mux[a_s];
  assign b_mux_out = b_mux[b_s];

  mux_scan_sequencer #(.SEL_W(3), .SETTLE(1)) dut_a (
    .clk(clk), .reset(a_reset), .start(a_start), .continuous(a_cont), .s(a_s),
    .mux_out(a_mux_out), .data(a_data), .valid(a_valid), .ready(a_ready), .busy(a_busy)
  );

  mux_scan_sequencer #(.SEL_W(3), .SETTLE(0)) dut_b (
    .clk(clk), .reset(b_reset), .start(b_start), .continuous(b_cont), .s(b_s),
    .mux_out(b_mux_out), .data(b_data), .valid(b_valid), .ready(b_ready), .busy(b_busy)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  int   timeouts = 0;
  int   b_words = 0;
  logic fin = 1'b0;

  mstate_t ma = '{mode: 0, b: 0, cyc: 0, word: 8'h00, data: 8'h00};
  mstate_t mb = '{mode: 0, b: 0, cyc: 0, word: 8'h00, data: 8'h00};
  exp_t    qa[$];
  exp_t    qb[$];
  logic    a_armed = 1'b0, b_armed = 1'b0, a_seen = 1'b0, b_seen = 1'b0;

  // Advance the model by one clock edge using the inputs that edge will sample.
  function automatic mstate_t step(input mstate_t m, input int settle, input logic rst,
                                   input logic st, input logic cont, input logic rdy,
                                   input logic [7:0] mi, output logic new_word);
    int c, pos, k;
    c        = m.cyc;
    m.cyc    = c + 1;
    new_word = 1'b0;
    if (rst) begin
      m.mode = 0;
      m.word = '0;
      m.data = '0;
    end else begin
      case (m.mode)
        0: if (st) begin
             m.mode = 1;
             m.b    = c + 1;
           end
        1: begin
             pos = c - m.b;
             if (pos % (settle + 1) == settle) begin
               k         = pos / (settle + 1);
               m.word[k] = mi[k];
               if (k == N - 1) begin
                 m.data   = m.word;
                 m.mode   = 2;
                 new_word = 1'b1;
               end
             end
           end
        2: if (rdy) begin
             m.mode = cont ? 1 : 0;
             m.b    = c + 1;
           end
        default: m.mode = 0;
      endcase
    end
    return m;
  endfunction

  function automatic int exp_s(input mstate_t m, input int settle);
    if (m.mode == 1) return (m.cyc - m.b) / (settle + 1);
    if (m.mode == 2) return N - 1;
    return 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare(input string tag, input mstate_t m, input int settle, input logic [2:0] s,
                         input logic valid, input logic busy, input logic [7:0] data);
    chk({tag, ".s"}, 32'(s), exp_s(m, settle));
    chk({tag, ".valid"}, 32'(valid), 32'(m.mode == 2));
    chk({tag, ".busy"}, 32'(busy), 32'(m.mode != 0));
    chk({tag, ".data"}, 32'(data), 32'(m.data));
  endtask

  // Monitor: compare current cycle, pop words as they appear, then step the models.
  always @(negedge clk) begin
    exp_t e;
    logic pw;
    if (fin) begin
      chk("a.leftover_words", qa.size(), 0);
      chk("b.leftover_words", qb.size(), 0);
      chk("b.word_count", b_words, 1);
      chk("timeouts", timeouts, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
    end else begin
      if (a_armed) begin
        compare("a", ma, 1, a_s, a_valid, a_busy, a_data);
        if (a_valid === 1'b1 && !a_seen) begin
          chk("a.word_expected", 32'(qa.size() > 0), 1);
          if (qa.size() > 0) begin
            e = qa.pop_front();
            chk("a.sb_word", 32'(a_data), 32'(e.word));
            chk("a.sb_cycle", ma.cyc, e.cyc);
          end
        end
        a_seen = (a_valid === 1'b1) && !a_ready && !a_reset;
      end
      if (b_armed) begin
        compare("b", mb, 0, b_s, b_valid, b_busy, b_data);
        if (b_valid === 1'b1 && !b_seen) begin
          b_words++;
          chk("b.word_expected", 32'(qb.size() > 0), 1);
          if (qb.size() > 0) begin
            e = qb.pop_front();
            chk("b.sb_word", 32'(b_data), 32'(e.word));
            chk("b.sb_cycle", mb.cyc, e.cyc);
          end
        end
        b_seen = (b_valid === 1'b1) && !b_ready && !b_reset;
      end
      ma = step(ma, 1, a_reset, a_start, a_cont, a_ready, a_mux, pw);
      if (pw) begin
        e.word = ma.data;
        e.cyc  = ma.cyc;
        qa.push_back(e);
      end
      mb = step(mb, 0, b_reset, b_start, b_cont, b_ready, b_mux, pw);
      if (pw) begin
        e.word = mb.data;
        e.cyc  = mb.cyc;
        qb.push_back(e);
      end
      if (a_reset === 1'b1) a_armed = 1'b1;
      if (b_reset === 1'b1) b_armed = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int max);
    int i;
    i = 0;
    while (a_valid !== 1'b1 && i < max) begin
      tick();
      i++;
    end
    if (a_valid !== 1'b1) begin
      $display("FAIL wait_valid: valid=%b after %0d cycles, expected 1", a_valid, max);
      timeouts++;
    end
  endtask

  task automatic wait_s4(input int max);
    int i;
    i = 0;
    while (a_s !== 3'd4 && i < max) begin
      tick();
      i++;
    end
    if (a_s !== 3'd4) begin
      $display("FAIL wait_s4: s=%0d after %0d cycles, expected 4", a_s, max);
      timeouts++;
    end
  endtask

  // SETTLE=0 build: one-shot with a second start ignored mid-scan.
  initial begin
    b_reset = 1'b1; b_start = 1'b0; b_cont = 1'b0; b_ready = 1'b1; b_mux = 8'h5A;
    repeat (3) tick();
    b_reset = 1'b0;
    tick();
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    repeat (3) tick();
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
  end

  initial begin
    a_reset = 1'b1; a_start = 1'b1; a_cont = 1'b0; a_ready = 1'b1; a_mux = 8'hA5;
    repeat (3) tick();
    a_reset = 1'b0; a_start = 1'b0;
    repeat (3) tick();

    // One-shot
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    repeat (20) tick();

    // Backpressure with continuous armed
    a_ready = 1'b0; a_cont = 1'b1;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    wait_valid(40);
    repeat (5) tick();
    a_ready = 1'b1;
    tick();
    a_cont = 1'b0;
    wait_valid(40);
    repeat (4) tick();

    // Continuous, pattern changed during the handshake
    a_cont = 1'b1; a_mux = 8'hA5;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    wait_valid(40);
    a_mux = 8'h3C;
    tick();
    wait_valid(40);
    a_cont = 1'b0;
    repeat (4) tick();

    // Reset mid-scan, then a clean scan
    a_mux = 8'h66;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    wait_s4(40);
    a_reset = 1'b1;
    tick();
    a_reset = 1'b0;
    repeat (2) tick();
    a_mux = 8'h81;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    repeat (20) tick();

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      a_reset = ($urandom_range(0, 99) == 0);
      a_start = ($urandom_range(0, 3) == 0);
      a_ready = 1'($urandom_range(0, 1));
      a_cont  = 1'($urandom_range(0, 1));
      a_mux   = 8'($urandom);
      tick();
    end
    a_reset = 1'b0; a_start = 1'b0; a_cont = 1'b0; a_ready = 1'b1;
    repeat (40) tick();
    fin = 1'b1;
  end

endmodule
